// File: rtl/sig_debounce_pkg.sv
// rtl/sig_debounce_pkg.sv - shared state type and sizing helper for sig_debounce
package sig_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_event_cnt.sv
// rtl/sat_event_cnt.sv - saturating event counter with sticky overflow flag
module sat_event_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // A clear that coincides with an event still counts that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= CNT_W'(inc);
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sig_debounce.sv
// rtl/sig_debounce.sv - debounce filter with registered rise/fall pulses and rise counter
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int   DB_CYCLES  = 4,
  parameter int   CNT_W      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             clr_cnt,
  output logic             db_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             cnt_ovf
);

  localparam int            SW        = clog2(DB_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DB_CYCLES - 1);

  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [SW-1:0] r_stab;
  logic [SW-1:0] w_stab_nxt;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;
  logic          w_db_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    case (r_state)
      ST_LO: begin
        if (sync_in) begin
          if (DB_CYCLES == 1) begin
            w_state_nxt = ST_HI;
          end else begin
            w_state_nxt = CHK_HI;
            w_stab_nxt  = SW'(1);
          end
        end
      end
      CHK_HI: begin
        if (!sync_in) begin
          w_state_nxt = ST_LO;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = ST_HI;
          w_stab_nxt  = '0;
        end else begin
          w_stab_nxt = r_stab + 1'b1;
        end
      end
      ST_HI: begin
        if (!sync_in) begin
          if (DB_CYCLES == 1) begin
            w_state_nxt = ST_LO;
          end else begin
            w_state_nxt = CHK_LO;
            w_stab_nxt  = SW'(1);
          end
        end
      end
      CHK_LO: begin
        if (sync_in) begin
          w_state_nxt = ST_HI;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = ST_LO;
          w_stab_nxt  = '0;
        end else begin
          w_stab_nxt = r_stab + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LO;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // Pulses key off the filtered level, so an aborted qualification never pulses.
  assign w_db_nxt = (w_state_nxt == ST_HI) || (w_state_nxt == CHK_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE_LEVEL ? ST_HI : ST_LO;
      r_stab  <= '0;
      r_db    <= IDLE_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stab  <= w_stab_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_db_nxt & ~r_db;
      r_fall  <= ~w_db_nxt & r_db;
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

  sat_event_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(r_rise),
    .clr(clr_cnt),
    .cnt(evt_cnt),
    .ovf(cnt_ovf)
  );

endmodule

// File: tb/tb_sig_debounce.sv
// tb/tb_sig_debounce.sv - directed self-checking bench for sig_debounce
module tb_sig_debounce;

  logic       clk;
  logic       rst;
  logic       sync_a, clr_a, db_a, rise_a, fall_a, ovf_a;
  logic [7:0] evt_a;
  logic       sync_b, clr_b, db_b, rise_b, fall_b, ovf_b;
  logic [1:0] evt_b;
  logic       sync_c, clr_c, db_c, rise_c, fall_c, ovf_c;
  logic [7:0] evt_c;

  int checks;
  int errors;

  sig_debounce #(.DB_CYCLES(4), .CNT_W(8), .IDLE_LEVEL(1'b1)) u_a (
    .clk(clk), .rst(rst), .sync_in(sync_a), .clr_cnt(clr_a), .db_out(db_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_cnt(evt_a), .cnt_ovf(ovf_a)
  );

  sig_debounce #(.DB_CYCLES(4), .CNT_W(2), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst(rst), .sync_in(sync_b), .clr_cnt(clr_b), .db_out(db_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_cnt(evt_b), .cnt_ovf(ovf_b)
  );

  sig_debounce #(.DB_CYCLES(1), .CNT_W(8), .IDLE_LEVEL(1'b1)) u_c (
    .clk(clk), .rst(rst), .sync_in(sync_c), .clr_cnt(clr_c), .db_out(db_c),
    .rise_pulse(rise_c), .fall_pulse(fall_c), .evt_cnt(evt_c), .cnt_ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({db_a, rise_a, fall_a, evt_a, ovf_a} !== {3'b100, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got db=%0b r=%0b f=%0b cnt=%0d ovf=%0b exp db=1 r=0 f=0 cnt=0 ovf=0",
               db_a, rise_a, fall_a, evt_a, ovf_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({db_a, rise_a, fall_a, evt_a} !== {3'b100, 8'd0}) begin
        errors++;
        $display("FAIL idle_cycle%0d got db=%0b r=%0b f=%0b cnt=%0d exp db=1 r=0 f=0 cnt=0",
                 i, db_a, rise_a, fall_a, evt_a);
      end
    end
  endtask

  task automatic test_glitch;
    sync_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({db_a, fall_a} !== 2'b10) begin
        errors++;
        $display("FAIL glitch_low%0d got db=%0b f=%0b exp db=1 f=0", i, db_a, fall_a);
      end
    end
    sync_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({db_a, rise_a, fall_a} !== 3'b100) begin
        errors++;
        $display("FAIL glitch_recover%0d got db=%0b r=%0b f=%0b exp 1 0 0", i, db_a, rise_a, fall_a);
      end
    end
    sync_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({db_a, fall_a} !== {(i < 3), (i == 3)}) begin
        errors++;
        $display("FAIL qual_low%0d got db=%0b f=%0b exp db=%0b f=%0b", i, db_a, fall_a, (i < 3), (i == 3));
      end
    end
  endtask

  task automatic test_pulses;
    int rises;
    int falls;
    rises = 0;
    falls = 0;
    for (int p = 0; p < 10; p++) begin
      sync_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        rises += int'(rise_a);
        falls += int'(fall_a);
        checks++;
        if ({rise_a, fall_a} !== {(i == 3), 1'b0}) begin
          errors++;
          $display("FAIL pulse%0d_hi%0d got r=%0b f=%0b exp r=%0b f=0", p, i, rise_a, fall_a, (i == 3));
        end
        if (i == 3 || i == 4) begin
          checks++;
          if (int'(evt_a) !== p + (i - 3)) begin
            errors++;
            $display("FAIL pulse%0d_cnt%0d got %0d exp %0d", p, i, evt_a, p + (i - 3));
          end
        end
      end
      sync_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        rises += int'(rise_a);
        falls += int'(fall_a);
        checks++;
        if ({rise_a, fall_a} !== {1'b0, (i == 3)}) begin
          errors++;
          $display("FAIL pulse%0d_lo%0d got r=%0b f=%0b exp r=0 f=%0b", p, i, rise_a, fall_a, (i == 3));
        end
      end
    end
    checks++;
    if (rises !== 10 || falls !== 10 || evt_a !== 8'd10) begin
      errors++;
      $display("FAIL pulse_totals got rises=%0d falls=%0d cnt=%0d exp 10 10 10", rises, falls, evt_a);
    end
  endtask

  task automatic test_saturate;
    int exp_cnt;
    sync_b = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int n = 1; n <= 5; n++) begin
      sync_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (n == 5 && i == 3) begin
          checks++;
          if (rise_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_rise5 got %0b exp 1", rise_b);
          end
          clr_b = 1'b1;
        end
        if (i == 4) begin
          clr_b = 1'b0;
          exp_cnt = (n == 5) ? 1 : ((n > 3) ? 3 : n);
          checks++;
          if (int'(evt_b) !== exp_cnt || ovf_b !== (n == 4)) begin
            errors++;
            $display("FAIL sat_rise%0d got cnt=%0d ovf=%0b exp cnt=%0d ovf=%0b",
                     n, evt_b, ovf_b, exp_cnt, (n == 4));
          end
        end
      end
      sync_b = 1'b0;
      for (int i = 0; i < 6; i++) tick();
    end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checks++;
    if ({evt_b, ovf_b} !== 3'b000) begin
      errors++;
      $display("FAIL sat_clr_only got cnt=%0d ovf=%0b exp cnt=0 ovf=0", evt_b, ovf_b);
    end
  endtask

  task automatic test_db1;
    sync_c = 1'b0;
    tick();
    checks++;
    if ({db_c, rise_c, fall_c} !== 3'b001) begin
      errors++;
      $display("FAIL db1_fall got db=%0b r=%0b f=%0b exp 0 0 1", db_c, rise_c, fall_c);
    end
    tick();
    tick();
    sync_c = 1'b1;
    tick();
    sync_c = 1'b0;
    checks++;
    if ({db_c, rise_c, fall_c} !== 3'b110) begin
      errors++;
      $display("FAIL db1_rise got db=%0b r=%0b f=%0b exp 1 1 0", db_c, rise_c, fall_c);
    end
    tick();
    checks++;
    if ({db_c, rise_c, fall_c} !== 3'b001) begin
      errors++;
      $display("FAIL db1_back got db=%0b r=%0b f=%0b exp 0 0 1", db_c, rise_c, fall_c);
    end
    tick();
    checks++;
    if ({db_c, rise_c, fall_c, evt_c} !== {3'b000, 8'd1}) begin
      errors++;
      $display("FAIL db1_settle got db=%0b r=%0b f=%0b cnt=%0d exp 0 0 0 1", db_c, rise_c, fall_c, evt_c);
    end
  endtask

  task automatic test_reset_mid;
    sync_a = 1'b1;
    tick();
    tick();
    checks++;
    if ({db_a, rise_a} !== 2'b00) begin
      errors++;
      $display("FAIL mid_qual got db=%0b r=%0b exp 0 0", db_a, rise_a);
    end
    sync_a = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({db_a, evt_a} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL mid_async_rst got db=%0b cnt=%0d exp db=1 cnt=0", db_a, evt_a);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({db_a, rise_a, fall_a} !== {(i < 3), 1'b0, (i == 3)}) begin
        errors++;
        $display("FAIL post_rst%0d got db=%0b r=%0b f=%0b exp db=%0b r=0 f=%0b",
                 i, db_a, rise_a, fall_a, (i < 3), (i == 3));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sync_a = 1'b1;
    sync_b = 1'b1;
    sync_c = 1'b1;
    clr_a  = 1'b0;
    clr_b  = 1'b0;
    clr_c  = 1'b0;
    test_reset();
    test_glitch();
    test_pulses();
    test_saturate();
    test_db1();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
